// File: rtl/spi_rd_pkg.sv
// Shared types and constants for the SPI flash line-fill read controller.
// Contents:
//   spi_rd_state_t : controller FSM states
//   OPC_READ       : plain read opcode (8'h03)
//   OPC_FAST       : fast read opcode (8'h0B)
//   DUMMY_BITS     : dummy SCLK periods issued after the address in fast-read builds
// Build option: define SPI_RD_FAST_EN to add the DUMMY state.
package spi_rd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_CMD,
    ST_ADDR,
`ifdef SPI_RD_FAST_EN
    ST_DUMMY,
`endif
    ST_DATA,
    ST_CS_HOLD
  } spi_rd_state_t;

  localparam logic [7:0] OPC_READ   = 8'h03;
  localparam logic [7:0] OPC_FAST   = 8'h0B;
  localparam int         DUMMY_BITS = 8;

endpackage

// File: rtl/spi_rx_byte.sv
// 8-bit MSB-first deserializer for the SPI receive path.
// Ports:
//   clk      : clock
//   rst      : synchronous active-high reset
//   i_start  : clears the bit counter at the start of a transaction
//   i_sample : shift i_miso in on this cycle's clock edge
//   i_miso   : serial input bit
//   o_byte   : assembled byte, valid while o_done is high
//   o_done   : high for one cycle, the cycle after the 8th sample of a byte
module spi_rx_byte
  import spi_rd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic       i_sample,
  input  logic       i_miso,
  output logic [7:0] o_byte,
  output logic       o_done
);

  logic [7:0] r_shift;
  logic [2:0] r_cnt;
  logic       r_done;

  always_ff @(posedge clk) begin
    if (rst || i_start) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= i_sample && (r_cnt == 3'd7);
      if (i_sample) r_cnt <= r_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_sample) r_shift <= {r_shift[6:0], i_miso};
  end

  assign o_byte = r_shift;
  assign o_done = r_done;

endmodule

// File: rtl/spi_rd_ctrl.sv
// SPI mode-0 flash read controller for cache line fills. One accepted request
// runs opcode, address, [dummy], then LINE_BYTES data bytes, which are returned
// one per beat on the rsp_* stream. SCLK runs at clk/2 and the first rising
// edge of each data byte waits until the output register can take the byte.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   req_valid/req_ready/req_addr   : line-fill request, address captured on handshake
//   rsp_valid/rsp_ready/rsp_data   : returned data bytes in address order
//   rsp_last                       : marks the final byte of the line
//   busy                           : high whenever the FSM is not idle
//   spi_cs_n/spi_sclk/spi_mosi/spi_miso : SPI flash pins
// Build option: SPI_RD_FAST_EN selects CMD_FAST plus DUMMY_BITS dummy periods;
// otherwise CMD_READ is used with no dummy phase.
module spi_rd_ctrl
  import spi_rd_pkg::*;
#(
  parameter int         ADDR_W     = 24,
  parameter int         LINE_BYTES = 16,
  parameter logic [7:0] CMD_READ   = OPC_READ,
  parameter logic [7:0] CMD_FAST   = OPC_FAST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [7:0]        rsp_data,
  output logic              rsp_last,
  output logic              busy,
  output logic              spi_cs_n,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

`ifdef SPI_RD_FAST_EN
  localparam bit FAST_EN = 1'b1;
`else
  localparam bit FAST_EN = 1'b0;
`endif

  localparam logic [7:0] OPCODE    = FAST_EN ? CMD_FAST : CMD_READ;
  localparam int         DATA_BITS = LINE_BYTES * 8;
  localparam int         TX_W      = 8 + ADDR_W;
  localparam int         MAX_BITS  = (DATA_BITS > TX_W) ? DATA_BITS : TX_W;
  localparam int         CNT_W     = $clog2(MAX_BITS) + 1;

  spi_rd_state_t    r_state, w_next;
  logic             r_phase;       // 0: SCLK low phase, 1: SCLK high phase
  logic [CNT_W-1:0] r_bit_cnt;     // bit index within the current state
  logic [TX_W-1:0]  r_tx;          // {opcode, address}, MSB shifted out first
  logic             r_mosi;
  logic [7:0]       r_rsp_data;
  logic             r_rsp_valid;
  logic             r_rsp_last;

  logic             w_bit_st;
  logic [CNT_W-1:0] w_last_idx;
  logic             w_stall, w_rise, w_fall, w_last_bit, w_start;
  logic [7:0]       w_rx_byte;
  logic             w_rx_done;

  assign req_ready = (r_state == ST_IDLE) && !r_rsp_valid;
  assign w_start   = req_valid && req_ready;

  always_comb begin
    w_next     = r_state;
    w_bit_st   = 1'b0;
    w_last_idx = CNT_W'(7);
    case (r_state)
      ST_CMD:   begin w_bit_st = 1'b1; w_last_idx = CNT_W'(7);           end
      ST_ADDR:  begin w_bit_st = 1'b1; w_last_idx = CNT_W'(ADDR_W - 1);  end
`ifdef SPI_RD_FAST_EN
      ST_DUMMY: begin w_bit_st = 1'b1; w_last_idx = CNT_W'(DUMMY_BITS - 1); end
`endif
      ST_DATA:  begin w_bit_st = 1'b1; w_last_idx = CNT_W'(DATA_BITS - 1); end
      default: ;
    endcase

    // Hold the first rising edge of a data byte while the previous byte is
    // still unaccepted, so a completed byte never overwrites the output.
    w_stall    = (r_state == ST_DATA) && (r_bit_cnt[2:0] == 3'd0) &&
                 r_rsp_valid && !rsp_ready;
    w_rise     = w_bit_st && !r_phase && !w_stall;
    w_fall     = w_bit_st && r_phase;
    w_last_bit = (r_bit_cnt == w_last_idx);

    case (r_state)
      ST_IDLE:     if (w_start) w_next = ST_CS_SETUP;
      ST_CS_SETUP: w_next = ST_CMD;
      ST_CMD:      if (w_fall && w_last_bit) w_next = ST_ADDR;
`ifdef SPI_RD_FAST_EN
      ST_ADDR:     if (w_fall && w_last_bit) w_next = ST_DUMMY;
      ST_DUMMY:    if (w_fall && w_last_bit) w_next = ST_DATA;
`else
      ST_ADDR:     if (w_fall && w_last_bit) w_next = ST_DATA;
`endif
      ST_DATA:     if (w_fall && w_last_bit) w_next = ST_CS_HOLD;
      ST_CS_HOLD:  w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_phase   <= 1'b0;
      r_bit_cnt <= '0;
      r_mosi    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_rise)      r_phase <= 1'b1;
      else if (w_fall) r_phase <= 1'b0;
      if (w_start)     r_bit_cnt <= '0;
      else if (w_fall) r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + CNT_W'(1);
      // MOSI moves on the falling edge; the next bit is the one just below the
      // current MSB, and CMD/ADDR are contiguous in r_tx.
      if (w_start)     r_mosi <= OPCODE[7];
      else if (w_fall) r_mosi <= ((w_next == ST_CMD) || (w_next == ST_ADDR)) ?
                                 r_tx[TX_W-2] : 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_start)
      r_tx <= {OPCODE, req_addr};
    else if (w_fall && ((r_state == ST_CMD) || (r_state == ST_ADDR)))
      r_tx <= {r_tx[TX_W-2:0], 1'b0};
  end

  spi_rx_byte u_rx (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_start),
    .i_sample (w_rise && (r_state == ST_DATA)),
    .i_miso   (spi_miso),
    .o_byte   (w_rx_byte),
    .o_done   (w_rx_done)
  );

  // Byte completion is reported during the high phase of its 8th bit, before
  // r_bit_cnt advances, so the counter still identifies the final byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_last  <= 1'b0;
      r_rsp_data  <= '0;
    end else if (w_rx_done) begin
      r_rsp_valid <= 1'b1;
      r_rsp_last  <= (r_bit_cnt == CNT_W'(DATA_BITS - 1));
      r_rsp_data  <= w_rx_byte;
    end else if (r_rsp_valid && rsp_ready) begin
      r_rsp_valid <= 1'b0;
      r_rsp_last  <= 1'b0;
      r_rsp_data  <= '0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_last  = r_rsp_last;
  assign busy      = (r_state != ST_IDLE);
  assign spi_cs_n  = (r_state == ST_IDLE);
  assign spi_sclk  = r_phase;
  assign spi_mosi  = r_mosi;

endmodule

// File: tb/tb_spi_rd_ctrl.sv
// Directed bench for spi_rd_ctrl with a behavioural SPI flash whose byte at
// address a is a[7:0] - 8'h56 (so 24'h123456 reads back 0x00..0x0F).
module tb_spi_rd_ctrl;

`ifdef SPI_RD_FAST_EN
  localparam logic [7:0] OPC = 8'h0B;
  localparam int         LAT = 98;
  localparam int         HDR = 40;
`else
  localparam logic [7:0] OPC = 8'h03;
  localparam int         LAT = 82;
  localparam int         HDR = 32;
`endif
  localparam int LB = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic        rsp_last;
  logic        busy;
  logic        spi_cs_n;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_miso = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  spi_rd_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_last  (rsp_last),
    .busy      (busy),
    .spi_cs_n  (spi_cs_n),
    .spi_sclk  (spi_sclk),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Flash model: decodes opcode/address from MOSI, shifts data out on SCLK falls.
  int          fl_bits = 0;
  int          fl_idx;
  logic [31:0] fl_sh = '0;
  logic [7:0]  fl_cmd = '0;
  logic [23:0] fl_addr = '0;
  logic [7:0]  fl_byte;
  logic        fl_dummy_or = 1'b0;
  logic        fl_data_or = 1'b0;

  always @(posedge spi_sclk or negedge spi_cs_n) begin
    if (!spi_sclk) begin
      fl_bits     = 0;
      fl_dummy_or = 1'b0;
      fl_data_or  = 1'b0;
    end else begin
      if (fl_bits < 32) begin
        fl_sh = {fl_sh[30:0], spi_mosi};
        if (fl_bits == 31) begin
          fl_cmd  = fl_sh[31:24];
          fl_addr = fl_sh[23:0];
        end
      end else if (fl_bits < HDR) begin
        fl_dummy_or = fl_dummy_or | spi_mosi;
      end else begin
        fl_data_or = fl_data_or | spi_mosi;
      end
      fl_bits = fl_bits + 1;
    end
  end

  always @(negedge spi_sclk) begin
    if (!spi_cs_n && fl_bits >= HDR) begin
      fl_idx   = fl_bits - HDR;
      fl_byte  = 8'(fl_addr + 24'(fl_idx / 8)) - 8'h56;
      spi_miso = fl_byte[7 - (fl_idx % 8)];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One line fill. base is the hand-computed first byte of the line.
  task automatic run_line(input logic [23:0] addr, input logic [7:0] base,
                          input int stall_at, input bit hold_next,
                          input logic [23:0] next_addr);
    int t;
    int got;
    int bad;
    int rr_bad;
    int cs_hi;
    int start;
    @(negedge clk);
    req_addr  = addr;
    req_valid = 1'b1;
    t = 0;
    cs_hi = spi_cs_n ? 1 : 0;
    while (req_ready !== 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
      if (spi_cs_n) cs_hi++;
    end
    check("accept_wait", (t < 1000), 1);
    check("cs_high_gap", (cs_hi >= 1), 1);
    start = cyc;
    @(negedge clk);
    if (hold_next) begin
      req_addr = next_addr;
    end else begin
      req_valid = 1'b0;
      req_addr  = ~addr;
    end
    check("setup_cs_n", spi_cs_n, 0);
    check("setup_sclk", spi_sclk, 0);
    check("setup_mosi", spi_mosi, OPC[7]);
    check("setup_busy", busy, 1);
    got = 0;
    t = 0;
    rr_bad = 0;
    while (got < LB && t < 3000) begin
      @(negedge clk);
      t++;
      if (req_ready !== 1'b0) rr_bad++;
      if (rsp_valid === 1'b1) begin
        if (got == 0) check("first_valid_cycle", cyc - start, LAT);
        if (got == stall_at) begin
          rsp_ready = 1'b0;
          bad = 0;
          repeat (100) begin
            @(negedge clk);
            t++;
            if (spi_sclk !== 1'b0 || spi_cs_n !== 1'b0 || rsp_valid !== 1'b1 ||
                rsp_data !== 8'(base + 8'(got)))
              bad++;
          end
          check("stall_hold", bad, 0);
          rsp_ready = 1'b1;
        end
        check($sformatf("beat%0d_data", got), rsp_data, 8'(base + 8'(got)));
        check($sformatf("beat%0d_last", got), rsp_last, (got == LB - 1));
        got++;
      end
    end
    check("beat_count", got, LB);
    check("req_ready_low_in_line", rr_bad, 0);
    check("flash_cmd", fl_cmd, OPC);
    check("flash_addr", fl_addr, addr);
    check("mosi_zero_data", fl_data_or, 0);
    check("mosi_zero_dummy", fl_dummy_or, 0);
  endtask

  initial begin : stim
    int t;
    int bad;
    int start;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_cs_n", spi_cs_n, 1);
    check("rst_sclk", spi_sclk, 0);
    check("rst_mosi", spi_mosi, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_last", rsp_last, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);

    // Basic read: 0x00..0x0F
    run_line(24'h123456, 8'h00, -1, 1'b0, 24'h0);
    // Backpressure after byte 3
    run_line(24'h123456, 8'h00, 3, 1'b0, 24'h0);
    // Back-to-back with req_valid held: 0x0A.. then 0x10..
    run_line(24'h00FF60, 8'h0A, -1, 1'b1, 24'h5A5A66);
    run_line(24'h5A5A66, 8'h10, -1, 1'b0, 24'h0);

    // Reset during ADDR bit 10 (low phase at cycle 38; addr bit 13 of 0xABEDEF is 1)
    @(negedge clk);
    req_addr  = 24'hABEDEF;
    req_valid = 1'b1;
    t = 0;
    while (req_ready !== 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    start = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    t = 0;
    while ((cyc - start) < 38 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("abort_reached_c38", cyc - start, 38);
    check("abort_addr_bit10_mosi", spi_mosi, 1);
    check("abort_addr_bit10_sclk", spi_sclk, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_cs_n", spi_cs_n, 1);
    check("abort_sclk", spi_sclk, 0);
    check("abort_busy", busy, 0);
    check("abort_mosi", spi_mosi, 0);
    check("abort_rsp_valid", rsp_valid, 0);
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || spi_cs_n !== 1'b1 || rsp_last !== 1'b0) bad++;
    end
    check("abort_quiet", bad, 0);

    // Normal request after the abort
    run_line(24'h5A5A66, 8'h10, -1, 1'b0, 24'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
